// File: rtl/fp_mult_pkg.sv
// Shared types and helpers for the pipelined IEEE-754 multiplier.
package fp_mult_pkg;

  // Operand classification produced in stage 1.
  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_SUBN,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp_class_e;

  // Special-case outcome, decided in stage 1 and carried down the pipe.
  typedef enum logic [1:0] {
    SPC_NONE,
    SPC_QNAN,
    SPC_INF,
    SPC_ZERO
  } fp_special_e;

  // Bit positions inside the packed flag vector.
  localparam int FLG_OVF = 0;
  localparam int FLG_UNF = 1;
  localparam int FLG_INV = 2;
  localparam int FLG_INX = 3;
  localparam int FLG_W   = 4;

  // Exponent bias for an exponent field of exp_w bits.
  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB set.
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    logic [63:0] r;
    r = ((64'd1 << exp_w) - 64'd1) << man_w;
    r = r | (64'd1 << (man_w - 1));
    return r;
  endfunction

  // Classify one operand from its field summary bits.
  function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                            input logic man_zero);
    if (exp_zero) return man_zero ? CLS_ZERO : CLS_SUBN;
    if (exp_ones) return man_zero ? CLS_INF : CLS_NAN;
    return CLS_NORM;
  endfunction

  // Resolve specials in priority order; subnormals count as zero.
  function automatic fp_special_e fp_special(input fp_class_e ca, input fp_class_e cb);
    logic za;
    logic zb;
    za = (ca == CLS_ZERO) || (ca == CLS_SUBN);
    zb = (cb == CLS_ZERO) || (cb == CLS_SUBN);
    if ((ca == CLS_NAN) || (cb == CLS_NAN)) return SPC_QNAN;
    if (((ca == CLS_INF) && zb) || ((cb == CLS_INF) && za)) return SPC_QNAN;
    if ((ca == CLS_INF) || (cb == CLS_INF)) return SPC_INF;
    if (za || zb) return SPC_ZERO;
    return SPC_NONE;
  endfunction

endpackage

// File: rtl/fp_mult_round.sv
// Stage-3 combinational normalise, round-to-nearest-even and pack.
module fp_mult_round
  import fp_mult_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int FW    = EXP_W + MAN_W + 1,
  localparam int EW2   = EXP_W + 2,
  localparam int PW    = 2 * MAN_W + 2
) (
  input  logic                  sign_i,
  input  logic signed [EW2-1:0] exp_i,
  input  logic [PW-1:0]         prod_i,
  input  logic [1:0]            spec_i,
  output logic [FW-1:0]         result_o,
  output logic [FLG_W-1:0]      flags_o
);

  localparam logic [FW-1:0]         QNAN    = FW'(fp_qnan(EXP_W, MAN_W));
  localparam logic signed [EW2-1:0] EXP_MAX = $signed({2'b00, {EXP_W{1'b1}}});

  fp_special_e           spec;
  logic [PW-2:0]         norm;
  logic [MAN_W-1:0]      mant;
  logic                  g_bit;
  logic                  r_bit;
  logic                  s_bit;
  logic                  rnd_up;
  logic [MAN_W:0]        mant_r;
  logic signed [EW2-1:0] exp_n;
  logic signed [EW2-1:0] exp_f;

  assign spec = fp_special_e'(spec_i);

  // Normalise the [1,4) product to a leading one, then round to nearest even.
  // A carry out of the rounded mantissa leaves the stored bits all zero, so
  // only the exponent needs bumping.
  always_comb begin
    norm   = prod_i[PW-1] ? prod_i[PW-2:0] : {prod_i[PW-3:0], 1'b0};
    exp_n  = exp_i + $signed({{(EW2-1){1'b0}}, prod_i[PW-1]});
    mant   = norm[PW-2:MAN_W+1];
    g_bit  = norm[MAN_W];
    r_bit  = norm[MAN_W-1];
    s_bit  = |norm[MAN_W-2:0];
    rnd_up = g_bit & (r_bit | s_bit | mant[0]);
    mant_r = {1'b0, mant} + {{MAN_W{1'b0}}, rnd_up};
    exp_f  = exp_n + $signed({{(EW2-1){1'b0}}, mant_r[MAN_W]});
  end

  // Select special, overflow, underflow or normal packed result with flags.
  always_comb begin
    result_o = '0;
    flags_o  = '0;
    case (spec)
      SPC_QNAN: begin
        result_o         = QNAN;
        flags_o[FLG_INV] = 1'b1;
      end
      SPC_INF: begin
        result_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
      SPC_ZERO: begin
        result_o = {sign_i, {(FW-1){1'b0}}};
      end
      default: begin
        if (exp_f >= EXP_MAX) begin
          result_o         = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_o[FLG_OVF] = 1'b1;
          flags_o[FLG_INX] = 1'b1;
        end else if (exp_f[EW2-1] || (exp_f == '0)) begin
          result_o         = {sign_i, {(FW-1){1'b0}}};
          flags_o[FLG_UNF] = 1'b1;
          flags_o[FLG_INX] = 1'b1;
        end else begin
          result_o         = {sign_i, exp_f[EXP_W-1:0], mant_r[MAN_W-1:0]};
          flags_o[FLG_INX] = g_bit | r_bit | s_bit;
        end
      end
    endcase
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined IEEE-754 multiplier with valid/ready on both sides.
// S1 unpack/classify/exponent sum, S2 mantissa product, S3 round and pack.
module fp_mult_pipe
  import fp_mult_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int FW    = EXP_W + MAN_W + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [FW-1:0] A,
  input  logic [FW-1:0] B,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [FW-1:0] result,
  output logic          overflow,
  output logic          underflow,
  output logic          invalid,
  output logic          inexact
);

  localparam int EW2 = EXP_W + 2;
  localparam int PW  = 2 * MAN_W + 2;
  localparam logic signed [EW2-1:0] BIAS = EW2'(fp_bias(EXP_W));

  // Stage 1 registers
  logic                  s1_v_q;
  logic                  s1_sign_q;
  logic signed [EW2-1:0] s1_exp_q;
  logic [MAN_W:0]        s1_ma_q;
  logic [MAN_W:0]        s1_mb_q;
  fp_special_e           s1_spec_q;
  // Stage 2 registers
  logic                  s2_v_q;
  logic                  s2_sign_q;
  logic signed [EW2-1:0] s2_exp_q;
  logic [PW-1:0]         s2_prod_q;
  fp_special_e           s2_spec_q;
  // Stage 3 (output) registers
  logic                  s3_v_q;
  logic [FW-1:0]         s3_res_q;
  logic [FLG_W-1:0]      s3_flg_q;

  // Next-state values
  logic                  s1_sign_d;
  logic signed [EW2-1:0] s1_exp_d;
  logic [MAN_W:0]        s1_ma_d;
  logic [MAN_W:0]        s1_mb_d;
  fp_special_e           s1_spec_d;
  logic [PW-1:0]         s2_prod_d;
  logic [FW-1:0]         s3_res_d;
  logic [FLG_W-1:0]      s3_flg_d;

  // Stage load enables
  logic                  s1_en;
  logic                  s2_en;
  logic                  s3_en;

  logic [EXP_W-1:0]      ea;
  logic [EXP_W-1:0]      eb;
  logic [MAN_W-1:0]      ma;
  logic [MAN_W-1:0]      mb;
  fp_class_e             cls_a;
  fp_class_e             cls_b;

  // A stage loads when it is empty or its contents move on this edge.
  always_comb begin
    s3_en    = !s3_v_q || out_ready;
    s2_en    = !s2_v_q || s3_en;
    s1_en    = !s1_v_q || s2_en;
    in_ready = s1_en;
  end

  // S1: unpack, classify, resolve specials, biased exponent sum.
  always_comb begin
    ea        = A[FW-2:MAN_W];
    eb        = B[FW-2:MAN_W];
    ma        = A[MAN_W-1:0];
    mb        = B[MAN_W-1:0];
    cls_a     = fp_classify(ea == '0, &ea, ma == '0);
    cls_b     = fp_classify(eb == '0, &eb, mb == '0);
    s1_spec_d = fp_special(cls_a, cls_b);
    s1_sign_d = A[FW-1] ^ B[FW-1];
    s1_exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
    s1_ma_d   = {1'b1, ma};
    s1_mb_d   = {1'b1, mb};
  end

  // S2: full-width mantissa product.
  always_comb begin
    s2_prod_d = {{(MAN_W+1){1'b0}}, s1_ma_q} * {{(MAN_W+1){1'b0}}, s1_mb_q};
  end

  fp_mult_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .sign_i   (s2_sign_q),
    .exp_i    (s2_exp_q),
    .prod_i   (s2_prod_q),
    .spec_i   (s2_spec_q),
    .result_o (s3_res_d),
    .flags_o  (s3_flg_d)
  );

  // Stage 1 register: capture classified operands on accept.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_v_q    <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_exp_q  <= '0;
      s1_ma_q   <= '0;
      s1_mb_q   <= '0;
      s1_spec_q <= SPC_NONE;
    end else if (s1_en) begin
      s1_v_q <= in_valid;
      if (in_valid) begin
        s1_sign_q <= s1_sign_d;
        s1_exp_q  <= s1_exp_d;
        s1_ma_q   <= s1_ma_d;
        s1_mb_q   <= s1_mb_d;
        s1_spec_q <= s1_spec_d;
      end
    end
  end

  // Stage 2 register: product plus the stage-1 classification.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s2_v_q    <= 1'b0;
      s2_sign_q <= 1'b0;
      s2_exp_q  <= '0;
      s2_prod_q <= '0;
      s2_spec_q <= SPC_NONE;
    end else if (s2_en) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_sign_q <= s1_sign_q;
        s2_exp_q  <= s1_exp_q;
        s2_prod_q <= s2_prod_d;
        s2_spec_q <= s1_spec_q;
      end
    end
  end

  // Stage 3 register: rounded result and flags, held while stalled.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s3_v_q   <= 1'b0;
      s3_res_q <= '0;
      s3_flg_q <= '0;
    end else if (s3_en) begin
      s3_v_q <= s2_v_q;
      if (s2_v_q) begin
        s3_res_q <= s3_res_d;
        s3_flg_q <= s3_flg_d;
      end
    end
  end

  assign out_valid = s3_v_q;
  assign result    = s3_res_q;
  assign overflow  = s3_flg_q[FLG_OVF];
  assign underflow = s3_flg_q[FLG_UNF];
  assign invalid   = s3_flg_q[FLG_INV];
  assign inexact   = s3_flg_q[FLG_INX];

endmodule
